// File: rtl/cpu_controller_pkg.sv
// Shared definitions for the lab CPU controller (package cpu_defs).
// Holds the state encoding, instruction field codes, nsel/vsel select codes,
// the packed controller output vector and a legality helper.
package cpu_defs;

   // 3-bit state encoding; code 3'd7 is unused and recovers to StWait.
   typedef enum logic [2:0] {
      StWait     = 3'd0,
      StDecode   = 3'd1,
      StGetA     = 3'd2,
      StGetB     = 3'd3,
      StExec     = 3'd4,
      StWriteReg = 3'd5,
      StWriteImm = 3'd6
   } state_e;

   // opcode field, instruction bits [15:13]
   localparam logic [2:0] MOVOP = 3'b110;
   localparam logic [2:0] ALUOP = 3'b101;

   // op field, instruction bits [12:11]
   localparam logic [1:0] ADD    = 2'b00;
   localparam logic [1:0] CMP    = 2'b01;
   localparam logic [1:0] AND    = 2'b10;
   localparam logic [1:0] MVN    = 2'b11;
   localparam logic [1:0] MOVIMM = 2'b10;
   localparam logic [1:0] MOVREG = 2'b00;

   // Register-field select, one-hot
   localparam logic [2:0] NSEL_RN   = 3'b100;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b001;
   localparam logic [2:0] NSEL_NONE = 3'b000;

   // Write-back source
   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

   typedef struct packed {
      logic       w;
      logic [2:0] nsel;
      logic [1:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       write;
      logic       illegal;
   } ctrl_out_t;

   // True for the six supported {opcode,op} combinations.
   function automatic logic is_legal(input logic [4:0] code);
      case (code)
         {MOVOP, MOVIMM},
         {MOVOP, MOVREG},
         {ALUOP, ADD},
         {ALUOP, CMP},
         {ALUOP, AND},
         {ALUOP, MVN}: is_legal = 1'b1;
         default:      is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> decoder/datapath bundle.
//   Decoder side : s (start), opcode[2:0], op[1:0]
//   Datapath side: w, nsel[2:0], vsel[1:0], loada, loadb, loadc, loads, asel,
//                  write, illegal
// master = controller view, slave = decoder/datapath (or bench) view.
interface cpu_controller_if;

   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;

   logic       w;
   logic [2:0] nsel;
   logic [1:0] vsel;
   logic       loada;
   logic       loadb;
   logic       loadc;
   logic       loads;
   logic       asel;
   logic       write;
   logic       illegal;

   modport master (
      input  s, opcode, op,
      output w, nsel, vsel, loada, loadb, loadc, loads, asel, write, illegal
   );

   modport slave (
      output s, opcode, op,
      input  w, nsel, vsel, loada, loadb, loadc, loads, asel, write, illegal
   );

endinterface

// File: rtl/cpu_ctrl_out.sv
// Combinational output decode for the CPU controller (Moore outputs).
//   state_i  : current controller state
//   code_i   : captured {opcode,op} of the instruction in flight
//   reset_i  : synchronous reset level; masks every load/write strobe
//   out_o    : packed controller output vector
module cpu_ctrl_out
   import cpu_defs::*;
(
   input  state_e     state_i,
   input  logic [4:0] code_i,
   input  logic       reset_i,
   output ctrl_out_t  out_o
);

   always_comb begin
      out_o = '0;
      case (state_i)
         StWait: begin
            out_o.w = 1'b1;
         end
         StDecode: begin
            out_o.illegal = ~is_legal(code_i);
         end
         StGetA: begin
            out_o.nsel  = NSEL_RN;
            out_o.loada = 1'b1;
         end
         StGetB: begin
            out_o.nsel  = NSEL_RM;
            out_o.loadb = 1'b1;
         end
         StExec: begin
            // CMP only updates status; MOV reg zeroes the ALU A input.
            if (code_i == {ALUOP, CMP}) begin
               out_o.loads = 1'b1;
            end else begin
               out_o.loadc = 1'b1;
            end
            out_o.asel = (code_i == {MOVOP, MOVREG});
         end
         StWriteReg: begin
            out_o.nsel  = NSEL_RD;
            out_o.vsel  = VSEL_C;
            out_o.write = 1'b1;
         end
         StWriteImm: begin
            out_o.nsel  = NSEL_RN;
            out_o.vsel  = VSEL_IMM;
            out_o.write = 1'b1;
         end
         default: begin
            out_o = '0;
         end
      endcase

      // No architectural state may change while reset is held, even if the
      // state register is still mid-instruction.
      if (reset_i) begin
         out_o.loada   = 1'b0;
         out_o.loadb   = 1'b0;
         out_o.loadc   = 1'b0;
         out_o.loads   = 1'b0;
         out_o.write   = 1'b0;
         out_o.illegal = 1'b0;
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// Moore controller sequencing the lab CPU datapath for MOV/ADD/CMP/AND/MVN.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : cpu_controller_if.master -- s/opcode/op in, datapath strobes out
// {opcode,op} is captured on the accepting edge so decoder changes while busy
// have no effect.
module cpu_controller
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   cpu_controller_if.master  bus
);

   state_e     state_q, state_d;
   logic [4:0] code_q, code_d;
   ctrl_out_t  ctrl;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StWait;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
      end
   end

   always_comb begin
      state_d = StWait;
      code_d  = code_q;
      case (state_q)
         StWait: begin
            if (bus.s) begin
               code_d  = {bus.opcode, bus.op};
               state_d = StDecode;
            end else begin
               state_d = StWait;
            end
         end
         StDecode: begin
            case (code_q)
               {MOVOP, MOVIMM}: state_d = StWriteImm;
               {MOVOP, MOVREG}: state_d = StGetB;
               {ALUOP, ADD},
               {ALUOP, AND},
               {ALUOP, CMP}:    state_d = StGetA;
               {ALUOP, MVN}:    state_d = StGetB;
               default:         state_d = StWait;
            endcase
         end
         StGetA: state_d = StGetB;
         StGetB: state_d = StExec;
         StExec: begin
            state_d = (code_q == {ALUOP, CMP}) ? StWait : StWriteReg;
         end
         StWriteReg: state_d = StWait;
         StWriteImm: state_d = StWait;
         default:    state_d = StWait;
      endcase
   end

   cpu_ctrl_out u_out (
      .state_i (state_q),
      .code_i  (code_q),
      .reset_i (reset),
      .out_o   (ctrl)
   );

   assign bus.w       = ctrl.w;
   assign bus.nsel    = ctrl.nsel;
   assign bus.vsel    = ctrl.vsel;
   assign bus.loada   = ctrl.loada;
   assign bus.loadb   = ctrl.loadb;
   assign bus.loadc   = ctrl.loadc;
   assign bus.loads   = ctrl.loads;
   assign bus.asel    = ctrl.asel;
   assign bus.write   = ctrl.write;
   assign bus.illegal = ctrl.illegal;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed per-cycle output checks plus a small
// behavioural datapath (regfile, A/B/C, shifter, ALU, status) driven by the
// controller strobes for end-to-end register checks.
module tb_cpu_controller;

   logic        clk;
   logic        reset;
   logic [15:0] instr;
   int          checks;
   int          errors;

   cpu_controller_if bus ();

   cpu_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.opcode = instr[15:13];
   assign bus.op     = instr[12:11];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {w, nsel, vsel, loada, loadb, loadc, loads, asel, write, illegal}
   logic [12:0] outs;
   assign outs = {bus.w, bus.nsel, bus.vsel, bus.loada, bus.loadb, bus.loadc,
                  bus.loads, bus.asel, bus.write, bus.illegal};

   localparam logic [12:0] E_WAIT  = 13'b1_000_00_0000000;
   localparam logic [12:0] E_DEC   = 13'b0_000_00_0000000;
   localparam logic [12:0] E_GETA  = 13'b0_100_00_1000000;
   localparam logic [12:0] E_GETB  = 13'b0_001_00_0100000;
   localparam logic [12:0] E_EXEC  = 13'b0_000_00_0010000;
   localparam logic [12:0] E_EXECM = 13'b0_000_00_0010100;
   localparam logic [12:0] E_EXECC = 13'b0_000_00_0001000;
   localparam logic [12:0] E_WREG  = 13'b0_010_00_0000010;
   localparam logic [12:0] E_WIMM  = 13'b0_100_01_0000010;
   localparam logic [12:0] E_ILL   = 13'b0_000_00_0000001;
   localparam logic [12:0] E_GETBR = 13'b0_001_00_0000000;

   // ---------------- behavioural datapath ----------------
   logic [15:0] rf [8];
   logic [15:0] a_q, b_q, c_q;
   logic [2:0]  stat_q;
   logic [2:0]  rnum;
   logic [15:0] b_sh, ain, alu;
   logic        ovf;
   logic        poke_en;
   logic [2:0]  poke_idx;
   logic [15:0] poke_val;

   always_comb begin
      case (bus.nsel)
         3'b100:  rnum = instr[10:8];
         3'b010:  rnum = instr[7:5];
         default: rnum = instr[2:0];
      endcase
      case (instr[4:3])
         2'b00:   b_sh = b_q;
         2'b01:   b_sh = {b_q[14:0], 1'b0};
         2'b10:   b_sh = {1'b0, b_q[15:1]};
         default: b_sh = {b_q[15], b_q[15:1]};
      endcase
      ain = bus.asel ? 16'h0000 : a_q;
      case (instr[12:11])
         2'b00:   alu = ain + b_sh;
         2'b01:   alu = ain - b_sh;
         2'b10:   alu = ain & b_sh;
         default: alu = ~b_sh;
      endcase
      if (instr[12:11] == 2'b01) ovf = (ain[15] != b_sh[15]) && (alu[15] != ain[15]);
      else                       ovf = (ain[15] == b_sh[15]) && (alu[15] != ain[15]);
   end

   always @(posedge clk) begin
      if (poke_en) begin
         rf[poke_idx] <= poke_val;
      end else begin
         if (bus.write) rf[rnum] <= (bus.vsel == 2'b01) ? {{8{instr[7]}}, instr[7:0]} : c_q;
         if (bus.loada) a_q <= rf[rnum];
         if (bus.loadb) b_q <= rf[rnum];
         if (bus.loadc) c_q <= alu;
         if (bus.loads) stat_q <= {alu[15], ovf, alu == 16'h0000};
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [15:0] ins);
      instr = ins;
      bus.s = 1'b1;
      @(posedge clk); #1;
      bus.s = 1'b0;
   endtask

   task automatic poke(input logic [2:0] idx, input logic [15:0] val);
      poke_idx = idx;
      poke_val = val;
      poke_en  = 1'b1;
      @(posedge clk); #1;
      poke_en  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1;
      bus.s = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (outs !== E_WAIT) begin
            errors++;
            $display("FAIL reset cycle %0d: got %b expected %b", i, outs, E_WAIT);
         end
      end
      bus.s = 1'b0;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (outs !== E_WAIT) begin
         errors++;
         $display("FAIL reset release idle: got %b expected %b", outs, E_WAIT);
      end
   endtask

   task automatic test_mov_imm;
      logic [12:0] exp_seq [3];
      exp_seq = '{E_DEC, E_WIMM, E_WAIT};
      issue(16'hD007); // MOV R0,#7
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== exp_seq[i]) begin
            errors++;
            $display("FAIL mov_imm step %0d: got %b expected %b", i, outs, exp_seq[i]);
         end
         if (i < 2) begin @(posedge clk); #1; end
      end
      checks++;
      if (rf[0] !== 16'h0007) begin
         errors++;
         $display("FAIL mov_imm R0: got %h expected 0007", rf[0]);
      end
   endtask

   task automatic test_add;
      logic [12:0] mov_seq [5];
      logic [12:0] add_seq [6];
      mov_seq = '{E_DEC, E_GETB, E_EXECM, E_WREG, E_WAIT};
      add_seq = '{E_DEC, E_GETA, E_GETB, E_EXEC, E_WREG, E_WAIT};
      issue(16'hC028); // MOV R1,R0,LSL#1
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== mov_seq[i]) begin
            errors++;
            $display("FAIL mov_lsl step %0d: got %b expected %b", i, outs, mov_seq[i]);
         end
         if (i < 4) begin @(posedge clk); #1; end
      end
      issue(16'hA148); // ADD R2,R1,R0,LSL#1
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (outs !== add_seq[i]) begin
            errors++;
            $display("FAIL add step %0d: got %b expected %b", i, outs, add_seq[i]);
         end
         if (i < 5) begin @(posedge clk); #1; end
      end
      checks++;
      if (rf[1] !== 16'h000E) begin
         errors++;
         $display("FAIL add R1: got %h expected 000e", rf[1]);
      end
      checks++;
      if (rf[2] !== 16'h001C) begin
         errors++;
         $display("FAIL add R2: got %h expected 001c", rf[2]);
      end
   endtask

   task automatic test_cmp;
      logic [12:0] cmp_seq [5];
      cmp_seq = '{E_DEC, E_GETA, E_GETB, E_EXECC, E_WAIT};
      issue(16'hD307); // MOV R3,#7
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (outs !== E_WAIT) begin
         errors++;
         $display("FAIL cmp setup wait: got %b expected %b", outs, E_WAIT);
      end
      issue(16'hAB00); // CMP R3,R0
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== cmp_seq[i]) begin
            errors++;
            $display("FAIL cmp step %0d: got %b expected %b", i, outs, cmp_seq[i]);
         end
         if (i < 4) begin @(posedge clk); #1; end
      end
      checks++;
      if (stat_q !== 3'b001) begin
         errors++;
         $display("FAIL cmp status: got %b expected 001", stat_q);
      end
      checks++;
      if ({rf[2], rf[3]} !== {16'h001C, 16'h0007}) begin
         errors++;
         $display("FAIL cmp no-write: got R2=%h R3=%h expected 001c 0007", rf[2], rf[3]);
      end
   endtask

   task automatic test_mov_reg_mvn;
      logic [12:0] mov_seq [5];
      logic [12:0] mvn_seq [5];
      mov_seq = '{E_DEC, E_GETB, E_EXECM, E_WREG, E_WAIT};
      mvn_seq = '{E_DEC, E_GETB, E_EXEC, E_WREG, E_WAIT};
      poke(3'd0, 16'h8000);
      issue(16'hC030); // MOV R1,R0,LSR#1
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== mov_seq[i]) begin
            errors++;
            $display("FAIL mov_reg step %0d: got %b expected %b", i, outs, mov_seq[i]);
         end
         if (i < 4) begin @(posedge clk); #1; end
      end
      checks++;
      if (rf[1] !== 16'h4000) begin
         errors++;
         $display("FAIL mov_reg R1: got %h expected 4000", rf[1]);
      end
      issue(16'hB841); // MVN R2,R1
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (outs !== mvn_seq[i]) begin
            errors++;
            $display("FAIL mvn step %0d: got %b expected %b", i, outs, mvn_seq[i]);
         end
         if (i < 4) begin @(posedge clk); #1; end
      end
      checks++;
      if (rf[2] !== 16'hBFFF) begin
         errors++;
         $display("FAIL mvn R2: got %h expected bfff", rf[2]);
      end
   endtask

   task automatic test_illegal;
      issue(16'hE000); // opcode 111
      checks++;
      if (outs !== E_ILL) begin
         errors++;
         $display("FAIL illegal decode: got %b expected %b", outs, E_ILL);
      end
      @(posedge clk); #1;
      checks++;
      if (outs !== E_WAIT) begin
         errors++;
         $display("FAIL illegal return: got %b expected %b", outs, E_WAIT);
      end
   endtask

   task automatic test_back_to_back;
      logic [12:0] seq [12];
      // s stays high: ADD runs to WAIT, then restarts on the following edge.
      seq = '{E_DEC, E_GETA, E_GETB, E_EXEC, E_WREG, E_WAIT,
              E_DEC, E_GETA, E_GETB, E_EXEC, E_WREG, E_WAIT};
      instr = 16'hA148; // ADD R2,R1,R0,LSL#1 : 4000 + 0000
      bus.s = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         if (i == 6) bus.s = 1'b0;
         checks++;
         if (outs !== seq[i]) begin
            errors++;
            $display("FAIL back_to_back step %0d: got %b expected %b", i, outs, seq[i]);
         end
         if (i < 11) begin @(posedge clk); #1; end
      end
      checks++;
      if (rf[2] !== 16'h4000) begin
         errors++;
         $display("FAIL back_to_back R2: got %h expected 4000", rf[2]);
      end
   endtask

   task automatic test_capture;
      logic [12:0] exp_seq [3];
      exp_seq = '{E_DEC, E_WIMM, E_WAIT};
      issue(16'hD412); // MOV R4,#0x12, then decoder switches to an illegal code
      instr = 16'hE000;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== exp_seq[i]) begin
            errors++;
            $display("FAIL capture step %0d: got %b expected %b", i, outs, exp_seq[i]);
         end
         if (i < 2) begin @(posedge clk); #1; end
      end
   endtask

   task automatic test_reset_midway;
      logic [12:0] exp_seq [3];
      exp_seq = '{E_DEC, E_GETA, E_GETB};
      issue(16'hA148);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs !== exp_seq[i]) begin
            errors++;
            $display("FAIL reset_mid step %0d: got %b expected %b", i, outs, exp_seq[i]);
         end
         if (i < 2) begin @(posedge clk); #1; end
      end
      reset = 1'b1;
      #1;
      checks++;
      if (outs !== E_GETBR) begin
         errors++;
         $display("FAIL reset_mid masked: got %b expected %b", outs, E_GETBR);
      end
      @(posedge clk); #1;
      checks++;
      if (outs !== E_WAIT) begin
         errors++;
         $display("FAIL reset_mid wait: got %b expected %b", outs, E_WAIT);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (outs !== E_WAIT) begin
         errors++;
         $display("FAIL reset_mid idle: got %b expected %b", outs, E_WAIT);
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.s    = 1'b0;
      instr    = 16'h0000;
      poke_en  = 1'b0;
      poke_idx = 3'd0;
      poke_val = 16'h0000;
      test_reset();
      test_mov_imm();
      test_add();
      test_cmp();
      test_mov_reg_mvn();
      test_illegal();
      test_back_to_back();
      test_capture();
      test_reset_midway();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
